ifetch: RTL
===========

Name: ifetch

Overview:
- Instruction fetch stage of the ONC-16 core, directly downstream of the program counter (pc).
- Reads the current PC value, issues a read to instruction memory over a req/ack handshake, and presents the fetched word to the decoder over a valid/ready handshake.
- Drives pc_adv into the pc count enable, so the PC advances only when an instruction has been accepted into this stage.
- On a taken branch (flush), discards in-flight and buffered instructions.

Parameters:
- DATA_W, 16, instruction/data word width (shared `DATA_W).
- ADDR_W, 16, instruction address width; equals PC width.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- pc  input  ADDR_W  current PC value from pc.
- flush  input  1  branch taken this cycle (same signal as pc bre); PC loads its target at this edge.
- pc_adv  output  1  combinational; PC increments at the edge where this is 1.
- mem_req  output  1  read request to instruction memory (registered).
- mem_addr  output  ADDR_W  read address; stable while mem_req=1 (registered).
- mem_ack  input  1  memory response; mem_rdata valid in the same cycle.
- mem_rdata  input  DATA_W  fetched instruction word.
- inst  output  DATA_W  instruction to decoder.
- inst_pc  output  ADDR_W  address of inst.
- inst_valid  output  1  inst/inst_pc valid.
- inst_ready  input  1  decoder accepts at the edge where inst_valid & inst_ready.

Behaviour:
- Reset (async, while rst=1):
  - state=IDLE; mem_req=0, mem_addr=0, inst=0, inst_pc=0, inst_valid=0.
  - flush_pending=0; skid registers cleared.
  - pc_adv=0.
- State IDLE: on the first edge after rst falls, go to ISSUE. mem_req=0.
- State ISSUE:
  - If flush=0: mem_addr<=pc, mem_req<=1, go to WAIT.
  - If flush=1: stay in ISSUE, mem_req stays 0. The PC changes at this edge, so it is not latched.
- State WAIT: mem_req=1 and mem_addr held until mem_ack. On mem_ack, mem_req<=0, then:
  - If flush=1 or flush_pending=1: drop the response, clear flush_pending, go to ISSUE, pc_adv=0.
  - Else if the output slot is free (inst_valid=0 or inst_ready=1):
    - inst<=mem_rdata, inst_pc<=mem_addr, inst_valid<=1.
    - pc_adv=1, go to ISSUE.
  - Else: skid<=mem_rdata, skid_pc<=mem_addr, go to HOLD, pc_adv=0.
  - flush=1 without mem_ack: flush_pending<=1. The request is never aborted; the ack is still awaited.
- State HOLD: mem_req=0.
  - If flush=1: drop skid, go to ISSUE.
  - Else if inst_ready=1: inst<=skid, inst_pc<=skid_pc, inst_valid stays 1, pc_adv=1, go to ISSUE.
- Output handshake:
  - inst_valid clears at an accept edge unless a new word is loaded at the same edge.
  - inst/inst_pc are stable while inst_valid=1 and inst_ready=0.
- flush in any state:
  - inst_valid<=0 at that edge.
  - flush has priority over inst_ready and mem_ack.
  - pc_adv=0 whenever flush=1.
- pc_adv = 1 only in the two capture cases above.
  - It is a combinational function of state, mem_ack, inst_ready, inst_valid and flush.
  - The PC then holds pc+1 in the next ISSUE cycle.
- Latency and throughput:
  - Zero-wait memory (ack in the first WAIT cycle) gives 1 instruction per 2 cycles.
  - An N-cycle ack adds N-1 cycles.
- Memory contract:
  - mem_ack is only honoured while mem_req=1.
  - A stray ack in IDLE/ISSUE/HOLD is ignored.
- No arithmetic in this block; addresses pass through unmodified, and wrap-around at 0xFFFF is the PC's concern.
- Reset mid-transaction: everything returns to reset values immediately and any outstanding ack is ignored. The memory must tolerate the dropped request.

Decomposition:
- def.v gains:
  - `IF_STATE_W = 2
  - `IF_IDLE = 2'd0, `IF_ISSUE = 2'd1, `IF_WAIT = 2'd2, `IF_HOLD = 2'd3
- Reuses `DATA_W.
- One natural sub-module, ifetch_skid: a one-entry buffer holding {skid, skid_pc} with load/drop controls. The FSM and handshake logic stay in ifetch.

Test Plan:
- Reset release with pc=0x0000 and zero-wait memory returning 0x1000+addr, inst_ready=1:
  - mem_addr sequence 0,1,2.
  - inst sequence 0x1000, 0x1001, 0x1002, with inst_valid every other cycle and pc_adv one pulse per capture.
- Memory ack delayed 3 cycles at pc=0x0010:
  - mem_req high 3 cycles with mem_addr=0x0010 stable.
  - inst=mem_rdata and inst_pc=0x0010 after the ack edge.
  - pc_adv=1 only in the ack cycle.
- inst_ready=0 for 5 cycles with inst valid at 0x0020:
  - inst/inst_pc are held, and the next word is parked in HOLD.
  - pc_adv=0 until inst_ready=1; then inst_pc becomes 0x0021 and pc_adv pulses once.
- flush while in WAIT for pc=0x0030, PC loaded with 0x0080:
  - the ack for 0x0030 is dropped and inst_valid=0.
  - the next mem_addr is 0x0080, and inst_pc=0x0080 is delivered.
- flush in the same cycle as mem_ack, and flush in HOLD:
  - no instruction is delivered and pc_adv=0.
  - the next fetch comes from the new PC (e.g. 0xFFF0).
- rst asserted mid-WAIT at a random phase:
  - all outputs immediately read 0.
  - after release, fetch restarts cleanly from the current pc.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and widths for the ONC-16 instruction fetch stage.
// Holds the word/address widths and the fetch FSM state encoding.
package ifetch_pkg;

  localparam int IF_DATA_W  = 16;
  localparam int IF_ADDR_W  = 16;
  localparam int IF_STATE_W = 2;

  typedef enum logic [IF_STATE_W-1:0] {
    IF_IDLE  = 2'd0,
    IF_ISSUE = 2'd1,
    IF_WAIT  = 2'd2,
    IF_HOLD  = 2'd3
  } if_state_e;

endpackage

// File: rtl/ifetch_skid.sv
// One-entry parking buffer for a fetched word and its address.
// Holds a memory response that arrived while the decoder slot was still full.
module ifetch_skid
  import ifetch_pkg::*;
#(
  parameter int DATA_W = IF_DATA_W,
  parameter int ADDR_W = IF_ADDR_W
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              load_i,
  input  logic              drop_i,
  input  logic [DATA_W-1:0] dat_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic [DATA_W-1:0] dat_o,
  output logic [ADDR_W-1:0] pc_o
);

  logic [DATA_W-1:0] dat_q;
  logic [ADDR_W-1:0] pc_q;

  // Capture on load, clear on drop (a flush discards the parked word).
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      dat_q <= '0;
      pc_q  <= '0;
    end else if (drop_i) begin
      dat_q <= '0;
      pc_q  <= '0;
    end else if (load_i) begin
      dat_q <= dat_i;
      pc_q  <= pc_i;
    end
  end

  assign dat_o = dat_q;
  assign pc_o  = pc_q;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: latches PC, reads instruction memory via req/ack, and
// hands words to the decoder via valid/ready. pc_adv pulses once per word
// accepted into this stage; a flush discards in-flight and buffered words.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int DATA_W = IF_DATA_W,
  parameter int ADDR_W = IF_ADDR_W
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  output logic              pc_adv,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready
);

  if_state_e         state_q;
  logic              flush_pending_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] inst_q;
  logic [ADDR_W-1:0] inst_pc_q;
  logic              inst_valid_q;

  logic              slot_free;
  logic              ack_take;
  logic              cap_mem;
  logic              cap_skid;
  logic              skid_load;
  logic              skid_drop;
  logic [DATA_W-1:0] skid_dat;
  logic [ADDR_W-1:0] skid_pc;

  // The decoder slot can take a new word if empty or being drained this edge.
  assign slot_free = !inst_valid_q || inst_ready;
  // mem_req is always high in WAIT, so an ack there is the only one honoured.
  assign ack_take  = (state_q == IF_WAIT) && mem_ack;
  // A response is useful only if no flush is current or remembered.
  assign cap_mem   = ack_take && !flush && !flush_pending_q && slot_free;
  assign skid_load = ack_take && !flush && !flush_pending_q && !slot_free;
  assign cap_skid  = (state_q == IF_HOLD) && !flush && inst_ready;
  assign skid_drop = (state_q == IF_HOLD) && flush;
  assign pc_adv    = cap_mem || cap_skid;

  ifetch_skid #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_skid (
    .clock  (clock),
    .rst    (rst),
    .load_i (skid_load),
    .drop_i (skid_drop),
    .dat_i  (mem_rdata),
    .pc_i   (mem_addr_q),
    .dat_o  (skid_dat),
    .pc_o   (skid_pc)
  );

  // Fetch FSM plus the registered decoder-side output slot.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q         <= IF_IDLE;
      flush_pending_q <= 1'b0;
      mem_req_q       <= 1'b0;
      mem_addr_q      <= '0;
      inst_q          <= '0;
      inst_pc_q       <= '0;
      inst_valid_q    <= 1'b0;
    end else begin
      if (flush) begin
        inst_valid_q <= 1'b0;
      end else if (cap_mem) begin
        inst_q       <= mem_rdata;
        inst_pc_q    <= mem_addr_q;
        inst_valid_q <= 1'b1;
      end else if (cap_skid) begin
        inst_q       <= skid_dat;
        inst_pc_q    <= skid_pc;
        inst_valid_q <= 1'b1;
      end else if (inst_ready) begin
        inst_valid_q <= 1'b0;
      end

      case (state_q)
        IF_IDLE: state_q <= IF_ISSUE;
        IF_ISSUE: begin
          // The PC reloads on a flush edge, so only latch it when stable.
          if (!flush) begin
            mem_addr_q <= pc;
            mem_req_q  <= 1'b1;
            state_q    <= IF_WAIT;
          end
        end
        IF_WAIT: begin
          if (mem_ack) begin
            mem_req_q       <= 1'b0;
            flush_pending_q <= 1'b0;
            state_q         <= skid_load ? IF_HOLD : IF_ISSUE;
          end else if (flush) begin
            // The request cannot be aborted; remember to drop its response.
            flush_pending_q <= 1'b1;
          end
        end
        IF_HOLD: begin
          if (flush || inst_ready) state_q <= IF_ISSUE;
        end
        default: state_q <= IF_IDLE;
      endcase
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = inst_valid_q;

endmodule
